sdram_addr_sequencer: RTL

//  Upstream address source for the SDRAM memory controller. Keeps a circular write pointer
//  and read pointer over one SDRAM region and tracks the fill level and flags.

---
 rtl/mem_map_pkg.sv | 31 +++
 rtl/sdram_wrap_ptr.sv | 38 +++
 rtl/sdram_addr_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Shared SDRAM memory-map definitions: field widths, command codes and the
// linear-address to {bank, row, column} split.
package mem_map_pkg;

  localparam int unsigned BA_W  = 2;
  localparam int unsigned ROW_W = 13;
  localparam int unsigned COL_W = 9;
  localparam int unsigned LIN_W = 24;

  typedef enum logic [1:0] {
    CmdNop    = 2'b00,
    CmdWrGeig = 2'b01,
    CmdWrMag  = 2'b10,
    CmdRead   = 2'b11
  } cmd_e;

  typedef struct packed {
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } bcr_t;

  function automatic bcr_t lin_to_bcr(input logic [LIN_W-1:0] lin);
    bcr_t bcr;
    bcr.ba  = lin[23:22];
    bcr.row = lin[21:9];
    bcr.col = lin[8:0];
    return bcr;
  endfunction

endpackage

// File: rtl/sdram_wrap_ptr.sv
// Circular word pointer over a region of DEPTH words; wraps from DEPTH-1 to 0
// and never leaves the region. Synchronous clear has priority over increment.
module sdram_wrap_ptr
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH = 32'h0080_0000
) (
  input  logic             CLK_48MHZ,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [LIN_W-1:0] ptr
);

  localparam logic [LIN_W-1:0] LastIdx = LIN_W'(DEPTH - 1);

  logic [LIN_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_48MHZ or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sdram_addr_sequencer.sv
// Circular write/read address source for one SDRAM region with fill tracking.
// Define SDRAM_ADDR_OVERWRITE_EN to let a write into a full region drop the oldest word.
module sdram_addr_sequencer
  import mem_map_pkg::*;
#(
  parameter logic [LIN_W-1:0] BASE_ADDR = 24'h000000,
  parameter int unsigned      DEPTH     = 32'h0080_0000
) (
  input  logic             CLK_48MHZ,
  input  logic             RST,
  input  logic             CLEAR,
  input  logic             NEXT_WRITE,
  input  logic             NEXT_READ,
  output logic [BA_W-1:0]  BA_WRITE,
  output logic [ROW_W-1:0] ROW_WRITE,
  output logic [COL_W-1:0] COL_WRITE,
  output logic [BA_W-1:0]  BA_READ,
  output logic [ROW_W-1:0] ROW_READ,
  output logic [COL_W-1:0] COL_READ,
  output logic [24:0]      FILL_COUNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam logic [24:0] DepthCnt = 25'(DEPTH);

  logic             nw_q, nr_q;
  logic [24:0]      cnt_q, cnt_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_ev, rd_ev, rd_acc, wr_blocked;
  logic             wr_inc, rd_inc;
  logic [LIN_W-1:0] wr_ptr, rd_ptr;
  bcr_t             wr_bcr, rd_bcr;

  always_comb begin
    wr_ev      = NEXT_WRITE & ~nw_q;
    rd_ev      = NEXT_READ & ~nr_q;
    rd_acc     = rd_ev & (cnt_q != '0);
    // A write that finds the region full with no read freeing a slot this edge
    wr_blocked = wr_ev & (cnt_q == DepthCnt) & ~rd_acc;
`ifdef SDRAM_ADDR_OVERWRITE_EN
    wr_inc     = wr_ev;
    rd_inc     = rd_acc | wr_blocked;
`else
    wr_inc     = wr_ev & ~wr_blocked;
    rd_inc     = rd_acc;
`endif
    cnt_d = cnt_q;
    if (wr_ev && !wr_blocked && !rd_acc) begin
      cnt_d = cnt_q + 25'd1;
    end else if (rd_acc && !wr_ev) begin
      cnt_d = cnt_q - 25'd1;
    end
    ovf_d = ovf_q | wr_blocked;
    udf_d = udf_q | (rd_ev & (cnt_q == '0));
    if (CLEAR) begin
      wr_inc = 1'b0;
      rd_inc = 1'b0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DepthCnt);
  end

  always_ff @(posedge CLK_48MHZ or posedge RST) begin
    if (RST) begin
      nw_q    <= 1'b0;
      nr_q    <= 1'b0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      nw_q    <= NEXT_WRITE;
      nr_q    <= NEXT_READ;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  sdram_wrap_ptr #(
    .DEPTH(DEPTH)
  ) u_wr_ptr (
    .CLK_48MHZ(CLK_48MHZ),
    .RST      (RST),
    .clr      (CLEAR),
    .inc      (wr_inc),
    .ptr      (wr_ptr)
  );

  sdram_wrap_ptr #(
    .DEPTH(DEPTH)
  ) u_rd_ptr (
    .CLK_48MHZ(CLK_48MHZ),
    .RST      (RST),
    .clr      (CLEAR),
    .inc      (rd_inc),
    .ptr      (rd_ptr)
  );

  assign wr_bcr = lin_to_bcr(BASE_ADDR + wr_ptr);
  assign rd_bcr = lin_to_bcr(BASE_ADDR + rd_ptr);

  assign BA_WRITE   = wr_bcr.ba;
  assign ROW_WRITE  = wr_bcr.row;
  assign COL_WRITE  = wr_bcr.col;
  assign BA_READ    = rd_bcr.ba;
  assign ROW_READ   = rd_bcr.row;
  assign COL_READ   = rd_bcr.col;
  assign FILL_COUNT = cnt_q;
  assign EMPTY      = empty_q;
  assign FULL       = full_q;
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = udf_q;

endmodule
